// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU codes, mux selects and the FSM-to-ALU-decoder opcode class.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET_S = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECUTE = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    IMMWB   = 4'd11,
    JUMP    = 4'd12,
    LOGICEX = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_LOGIC = 2'b11
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ASB_REGB = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_SEXT = 2'b10;
  localparam logic [1:0] ASB_ZEXT = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // True when the opcode/funct pair is something the FSM can sequence.
  function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);
`ifdef MC_IMMLOGIC_EN
      OP_ANDI, OP_ORI: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Memory handshake bundle between the control unit (master) and shared memory (slave).
interface mips_mc_control_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/mips_mc_control_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's operation class plus funct/op to alucont.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  input  logic [5:0] op,
  output logic [2:0] alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucont = ALU_ADD;
          FN_SUB:  alucont = ALU_SUB;
          FN_AND:  alucont = ALU_AND;
          FN_OR:   alucont = ALU_OR;
          FN_SLT:  alucont = ALU_SLT;
          default: alucont = ALU_ADD;
        endcase
      end
      ALUOP_LOGIC: alucont = (op == OP_ANDI) ? ALU_AND : ALU_OR;
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM. Define MC_IMMLOGIC_EN to add andi/ori (LOGICEX state);
// without it those opcodes raise illegal_op.
module mips_mc_control
  import mips_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [5:0]                 op,
  input  logic [5:0]                 funct,
  input  logic                       zero,
  mips_mc_control_if.master          mem_bus,
  output logic                       ir_write,
  output logic                       reg_write,
  output logic                       reg_dst,
  output logic                       mem_to_reg,
  output logic                       alusrca,
  output logic [1:0]                 alusrcb,
  output logic [2:0]                 alucont,
  output logic [1:0]                 pcsrc,
  output logic                       pcen,
  output logic                       illegal_op
);

  state_t     state, next_state;
  aluop_t     aluop;
  logic       alu_use;
  logic [2:0] dec_alucont;
  logic       mem_req, mem_write, iord;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_S;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RESET_S: next_state = FETCH;
      FETCH:   next_state = mem_bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        next_state = FETCH;
        if (instr_legal(op, funct)) begin
          case (op)
            OP_LW, OP_SW: next_state = MEMADR;
            OP_RTYPE:     next_state = EXECUTE;
            OP_BEQ:       next_state = BRANCH;
            OP_ADDI:      next_state = ADDIEX;
            OP_J:         next_state = JUMP;
`ifdef MC_IMMLOGIC_EN
            OP_ANDI, OP_ORI: next_state = LOGICEX;
`endif
            default:      next_state = FETCH;
          endcase
        end
      end
      MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   next_state = mem_bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:   next_state = FETCH;
      MEMWR:   next_state = mem_bus.mem_ready ? FETCH : MEMWR;
      EXECUTE: next_state = ALUWB;
      ALUWB:   next_state = FETCH;
      BRANCH:  next_state = FETCH;
      ADDIEX:  next_state = IMMWB;
      IMMWB:   next_state = FETCH;
      JUMP:    next_state = FETCH;
`ifdef MC_IMMLOGIC_EN
      LOGICEX: next_state = IMMWB;
`endif
      default: next_state = RESET_S;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = ASB_REGB;
    pcsrc      = PCS_ALU;
    pcen       = 1'b0;
    illegal_op = 1'b0;
    alu_use    = 1'b0;
    aluop      = ALUOP_ADD;
    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        alusrcb  = ASB_FOUR;
        alu_use  = 1'b1;
        ir_write = mem_bus.mem_ready;
        pcen     = mem_bus.mem_ready;
      end
      DECODE: begin
        alusrcb    = ASB_SEXT;
        alu_use    = 1'b1;
        illegal_op = ~instr_legal(op, funct);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ASB_SEXT;
        alu_use = 1'b1;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        alu_use = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        alu_use = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCS_ALUOUT;
        pcen    = zero;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ASB_SEXT;
        alu_use = 1'b1;
      end
      IMMWB: reg_write = 1'b1;
      JUMP: begin
        pcsrc = PCS_JUMP;
        pcen  = 1'b1;
      end
`ifdef MC_IMMLOGIC_EN
      LOGICEX: begin
        alusrca = 1'b1;
        alusrcb = ASB_ZEXT;
        alu_use = 1'b1;
        aluop   = ALUOP_LOGIC;
      end
`endif
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop   (aluop),
    .funct   (funct),
    .op      (op),
    .alucont (dec_alucont)
  );

  // States that do not use the ALU report code 000 so every unlisted output is zero.
  assign alucont           = alu_use ? dec_alucont : 3'b000;
  assign mem_bus.mem_req   = mem_req;
  assign mem_bus.mem_write = mem_write;
  assign mem_bus.iord      = iord;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: directed per-cycle vectors, expectations queued
// by the stimulus and checked by an independent negedge monitor.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       ir_write, reg_write, reg_dst, mem_to_reg, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_bus    (bus.master),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucont    (alucont),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Field order: mem_req mem_write iord ir_write reg_write reg_dst mem_to_reg alusrca
  //              alusrcb[2] alucont[3] pcsrc[2] pcen illegal_op
  localparam logic [16:0] E_ZERO      = 17'b0;
  localparam logic [16:0] E_FETCH_W   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_FETCH_G   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,2'b00,1'b1,1'b0};
  localparam logic [16:0] E_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b010,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_DEC_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b010,2'b00,1'b0,1'b1};
  localparam logic [16:0] E_MEMADR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_MEMRD     = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_MEMWB     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_MEMWR     = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_EX_SLT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b111,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_EX_SUB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_EX_AND    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_ALUWB     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_BR_T      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b01,1'b1,1'b0};
  localparam logic [16:0] E_BR_N      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b110,2'b01,1'b0,1'b0};
  localparam logic [16:0] E_ADDIEX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_IMMWB     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0};
  localparam logic [16:0] E_JUMP      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,1'b1,1'b0};
  localparam logic [16:0] E_LOGIC_OR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,3'b001,2'b00,1'b0,1'b0};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, ORI = 6'b001101;

  logic [16:0] exp_q [$];
  string       name_q [$];
  int          checks = 0;
  int          failures = 0;
  logic [16:0] act;

  assign act = {bus.mem_req, bus.mem_write, bus.iord, ir_write, reg_write, reg_dst, mem_to_reg,
                alusrca, alusrcb, alucont, pcsrc, pcen, illegal_op};

  // One clock cycle of stimulus with the outputs expected during that cycle.
  task automatic step(input logic r, input logic mr, input logic z, input logic [5:0] o,
                      input logic [5:0] f, input logic [16:0] e, input string nm);
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.mem_ready = mr;
    zero          = z;
    op            = o;
    funct         = f;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: outputs=%b required=%b", nm, act, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; bus.mem_ready = 1'b1; zero = 1'b0; op = 6'b0; funct = 6'b0;
    step(0, 1, 0, RT,  6'h00, E_ZERO,    "reset_hold0");
    step(0, 1, 0, RT,  6'h00, E_ZERO,    "reset_hold1");
    step(1, 1, 0, RT,  6'h00, E_ZERO,    "reset_release");
    // lw with memory always ready: 5 cycles
    step(1, 1, 0, LW,  6'h00, E_FETCH_G, "lw_fetch");
    step(1, 1, 0, LW,  6'h00, E_DECODE,  "lw_decode");
    step(1, 1, 0, LW,  6'h00, E_MEMADR,  "lw_memadr");
    step(1, 1, 0, LW,  6'h00, E_MEMRD,   "lw_memrd");
    step(1, 1, 0, LW,  6'h00, E_MEMWB,   "lw_memwb");
    // sw with one MEMWR stall; mem_ready low in DECODE must be ignored
    step(1, 1, 0, SW,  6'h00, E_FETCH_G, "sw_fetch");
    step(1, 0, 0, SW,  6'h00, E_DECODE,  "sw_decode");
    step(1, 1, 0, SW,  6'h00, E_MEMADR,  "sw_memadr");
    step(1, 0, 0, SW,  6'h00, E_MEMWR,   "sw_memwr_stall");
    step(1, 1, 0, SW,  6'h00, E_MEMWR,   "sw_memwr_done");
    // fetch stalled 3 cycles, then slt
    step(1, 0, 0, RT,  6'h2a, E_FETCH_W, "stall_fetch1");
    step(1, 0, 0, RT,  6'h2a, E_FETCH_W, "stall_fetch2");
    step(1, 0, 0, RT,  6'h2a, E_FETCH_W, "stall_fetch3");
    step(1, 1, 0, RT,  6'h2a, E_FETCH_G, "stall_fetch_go");
    step(1, 1, 0, RT,  6'h2a, E_DECODE,  "slt_decode");
    step(1, 1, 0, RT,  6'h2a, E_EX_SLT,  "slt_execute");
    step(1, 1, 0, RT,  6'h2a, E_ALUWB,   "slt_aluwb");
    // sub
    step(1, 1, 0, RT,  6'h22, E_FETCH_G, "sub_fetch");
    step(1, 1, 0, RT,  6'h22, E_DECODE,  "sub_decode");
    step(1, 1, 0, RT,  6'h22, E_EX_SUB,  "sub_execute");
    step(1, 1, 0, RT,  6'h22, E_ALUWB,   "sub_aluwb");
    // and
    step(1, 1, 0, RT,  6'h24, E_FETCH_G, "and_fetch");
    step(1, 1, 0, RT,  6'h24, E_DECODE,  "and_decode");
    step(1, 1, 0, RT,  6'h24, E_EX_AND,  "and_execute");
    step(1, 1, 0, RT,  6'h24, E_ALUWB,   "and_aluwb");
    // beq taken then not taken; zero only matters in BRANCH
    step(1, 1, 0, BEQ, 6'h00, E_FETCH_G, "beqt_fetch");
    step(1, 1, 0, BEQ, 6'h00, E_DECODE,  "beqt_decode");
    step(1, 1, 1, BEQ, 6'h00, E_BR_T,    "beqt_branch");
    step(1, 1, 1, BEQ, 6'h00, E_FETCH_G, "beqn_fetch");
    step(1, 1, 1, BEQ, 6'h00, E_DECODE,  "beqn_decode");
    step(1, 1, 0, BEQ, 6'h00, E_BR_N,    "beqn_branch");
    // addi
    step(1, 1, 0, ADDI, 6'h00, E_FETCH_G, "addi_fetch");
    step(1, 1, 0, ADDI, 6'h00, E_DECODE,  "addi_decode");
    step(1, 1, 0, ADDI, 6'h00, E_ADDIEX,  "addi_exec");
    step(1, 1, 0, ADDI, 6'h00, E_IMMWB,   "addi_immwb");
    // j
    step(1, 1, 0, JMP, 6'h00, E_FETCH_G, "j_fetch");
    step(1, 1, 0, JMP, 6'h00, E_DECODE,  "j_decode");
    step(1, 1, 0, JMP, 6'h00, E_JUMP,    "j_jump");
    // ori
    step(1, 1, 0, ORI, 6'h00, E_FETCH_G, "ori_fetch");
`ifdef MC_IMMLOGIC_EN
    step(1, 1, 0, ORI, 6'h00, E_DECODE,   "ori_decode");
    step(1, 1, 0, ORI, 6'h00, E_LOGIC_OR, "ori_logicex");
    step(1, 1, 0, ORI, 6'h00, E_IMMWB,    "ori_immwb");
`else
    step(1, 1, 0, ORI, 6'h00, E_DEC_ILL,  "ori_illegal");
`endif
    // R-type with unsupported funct
    step(1, 1, 0, RT,  6'h07, E_FETCH_G, "badfn_fetch");
    step(1, 1, 0, RT,  6'h07, E_DEC_ILL, "badfn_illegal");
    // lw stalled in MEMRD, then reset mid-access
    step(1, 1, 0, LW,  6'h00, E_FETCH_G, "rst_lw_fetch");
    step(1, 1, 0, LW,  6'h00, E_DECODE,  "rst_lw_decode");
    step(1, 1, 0, LW,  6'h00, E_MEMADR,  "rst_lw_memadr");
    step(1, 0, 0, LW,  6'h00, E_MEMRD,   "rst_lw_memrd_stall1");
    step(1, 0, 0, LW,  6'h00, E_MEMRD,   "rst_lw_memrd_stall2");
    step(0, 0, 0, LW,  6'h00, E_ZERO,    "rst_mid_memrd");
    step(1, 0, 0, JMP, 6'h00, E_ZERO,    "rst_release2");
    step(1, 0, 0, JMP, 6'h00, E_FETCH_W, "rst_first_fetch");
    step(1, 1, 0, JMP, 6'h00, E_FETCH_G, "rst_fetch_go");
    step(1, 1, 0, JMP, 6'h00, E_DECODE,  "rst_j_decode");
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle MIPS control unit that produces the per-cycle datapath controls, including the 3-bit `alucont` code consumed by the ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Handles a ready/request memory handshake so memory can stall the sequence.
- Sits between the instruction register and the shared-memory multicycle datapath.

## Interface
Parameters:
- none; all encodings live in the package.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `op`  in  6  instruction opcode, `instr[31:26]`, held stable by the IR.
- `funct`  in  6  R-type function, `instr[5:0]`.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `mem_write`  out  1  the access is a write.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the instruction register.
- `reg_write`  out  1  register file write.
- `reg_dst`  out  1  write-register select: 1 = rd, 0 = rt.
- `mem_to_reg`  out  1  write-data select: 1 = data register, 0 = ALUOut.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B select: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = zero-extended immediate.
- `alucont`  out  3  ALU operation code.
- `pcsrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen`  out  1  PC write enable.
- `illegal_op`  out  1  one-cycle pulse on an unsupported instruction.

## Operation
ALU codes:
- `and` = 000, `or` = 001, `add` = 010, `sub` = 110, `slt` = 111.
- Codes 100 and 101 are never emitted.

States, with the outputs each one asserts (every output not listed is 0):
- RESET_S: all outputs 0; goes to FETCH unconditionally.
- FETCH: `mem_req`, `alusrcb` = 01, `alucont` = add.
  - While `mem_ready` is 0: stay in FETCH, `ir_write` = 0, `pcen` = 0.
  - When `mem_ready` is 1: `ir_write` = 1 and `pcen` = 1; go to DECODE.
- DECODE: `alusrcb` = 10, `alucont` = add (branch target). Next state by opcode:
  - lw (100011) or sw (101011): MEMADR.
  - R-type (000000): EXECUTE.
  - beq (000100): BRANCH.
  - addi (001000): ADDIEX.
  - j (000010): JUMP.
  - Anything else, or R-type with a funct outside add/sub/and/or/slt (100000, 100010, 100100, 100101, 101010): `illegal_op` = 1, go to FETCH.
- MEMADR: `alusrca` = 1, `alusrcb` = 10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req`, `iord`. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`, `mem_to_reg`; goes to FETCH.
- MEMWR: `mem_req`, `mem_write`, `iord`. Waits for `mem_ready`, then goes to FETCH.
- EXECUTE: `alusrca` = 1, `alusrcb` = 00, `alucont` decoded from `funct`; goes to ALUWB.
- ALUWB: `reg_write`, `reg_dst`; goes to FETCH.
- BRANCH: `alusrca` = 1, sub, `pcsrc` = 01, `pcen` = `zero`; goes to FETCH.
- ADDIEX: `alusrca` = 1, `alusrcb` = 10, add; goes to IMMWB.
- IMMWB: `reg_write`, `reg_dst` = 0; goes to FETCH.
- JUMP: `pcsrc` = 10, `pcen` = 1; goes to FETCH.

Output rules:
- All outputs are combinational from the state, plus `mem_ready`/`zero` where noted. Outputs are glitch-free only relative to `clk`.
- `mem_req` stays high and its qualifiers stay stable until the cycle `mem_ready` is sampled high.

## Timing
- Reset: asserting `rst_n` forces RESET_S immediately and asynchronously, so every output is 0. This holds even mid-access; an in-flight request is abandoned. The first FETCH is one cycle after release.
- Minimum cycles per instruction, with `mem_ready` already high:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
  - Each memory stall cycle adds one.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `illegal_op` is high for exactly one cycle (DECODE) and never in any other state.
- The branch decision uses `zero` in the BRANCH cycle only.

## Configuration
- `MC_IMMLOGIC_EN` defined: andi (001100) and ori (001101) decode to a LOGICEX state with `alusrca` = 1, `alusrcb` = 11 and `alucont` = and/or, followed by IMMWB.
- Undefined: those opcodes are illegal (`illegal_op` pulse), and `alusrcb` never takes the value 11.

## Structure
- Package `mips_ctrl_pkg`:
  - state enum;
  - opcode and funct localparams;
  - ALU code localparams;
  - `alusrcb` and `pcsrc` select encodings;
  - `aluop_t` 2-bit enum: add, sub, funct, logic-imm.
- Sub-module `alu_decoder`: combinational; inputs `aluop`, `funct`, `op`; output `alucont`. The FSM drives `aluop`.

## Test plan
- Reset during MEMRD (`rst_n` low mid-stall) -> all outputs 0 the same cycle; FETCH with `mem_req` = 1 one cycle after release.
- lw (op 100011), `mem_ready` held 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `reg_write` = 1 and `mem_to_reg` = 1 on cycle 5.
- FETCH with `mem_ready` low for 3 cycles -> `ir_write` and `pcen` stay 0 for 3 cycles, then a single-cycle pulse of both.
- R-type with funct 101010 -> `alucont` = 111 in EXECUTE; funct 100010 -> 110.
- beq: `zero` = 1 -> `pcen` = 1 with `pcsrc` = 01; `zero` = 0 -> `pcen` = 0; FETCH follows in both cases.
- op 001101 (ori) -> `illegal_op` pulse when `MC_IMMLOGIC_EN` is undefined; with it defined, `alusrcb` = 11 and `alucont` = 001, then `reg_write` = 1 with `reg_dst` = 0.
